// File: rtl/sm4_pkg.sv
// Shared SM4 constants and types for the key schedule and round datapath.
// SM4_CK_ROM_EN selects a stored CK table instead of the on-the-fly CK generator.
package sm4_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam word_t Fk [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

`ifdef SM4_CK_ROM_EN
  localparam word_t CkRom [32] = '{
    32'h00070E15, 32'h1C232A31, 32'h383F464D, 32'h545B6269,
    32'h70777E85, 32'h8C939AA1, 32'hA8AFB6BD, 32'hC4CBD2D9,
    32'hE0E7EEF5, 32'hFC030A11, 32'h181F262D, 32'h343B4249,
    32'h50575E65, 32'h6C737A81, 32'h888F969D, 32'hA4ABB2B9,
    32'hC0C7CED5, 32'hDCE3EAF1, 32'hF8FF060D, 32'h141B2229,
    32'h30373E45, 32'h4C535A61, 32'h686F767D, 32'h848B9299,
    32'hA0A7AEB5, 32'hBCC3CAD1, 32'hD8DFE6ED, 32'hF4FB0209,
    32'h10171E25, 32'h2C333A41, 32'h484F565D, 32'h646B7279
  };
`else
  // Byte j (MSB first) of CK[idx] is 28*idx + 7*j, wrapping at 8 bits.
  function automatic word_t ck_calc(input logic [4:0] idx);
    logic [7:0] base;
    base = {3'b000, idx} * 8'd28;
    return {base, base + 8'd7, base + 8'd14, base + 8'd21};
  endfunction
`endif

  localparam logic [7:0] Sbox [256] = '{
    8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7,
    8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
    8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3,
    8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A,
    8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
    8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95,
    8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
    8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA,
    8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
    8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B,
    8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
    8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2,
    8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52,
    8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
    8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5,
    8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
    8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55,
    8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
    8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60,
    8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
    8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F,
    8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
    8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F,
    8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
    8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD,
    8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
    8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E,
    8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
    8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20,
    8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
  };

endpackage

// File: rtl/roll_shifter.sv
// Constant-distance rotator; pure wiring once Shift and Left are fixed.
module roll_shifter #(
  parameter int unsigned Width = 32,
  parameter int unsigned Shift = 1,
  parameter bit          Left  = 1'b1
) (
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  if (Left) begin : g_left
    assign data_o = (data_i << Shift) | (data_i >> (Width - Shift));
  end else begin : g_right
    assign data_o = (data_i >> Shift) | (data_i << (Width - Shift));
  end

endmodule

// File: rtl/sm4_sbox32.sv
// SM4 tau: four parallel byte S-box lookups on a 32-bit word.
module sm4_sbox32
  import sm4_pkg::*;
(
  input  word_t data_i,
  output word_t data_o
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign data_o[8*i +: 8] = Sbox[data_i[8*i +: 8]];
  end

endmodule

// File: rtl/sm4_key_expander.sv
// Iterative SM4 key schedule: one round key per rk handshake, 32 per master key.
// Define SM4_CK_ROM_EN to read CK from a stored table rather than generating it.
module sm4_key_expander
  import sm4_pkg::*;
#(
  parameter int unsigned rounds_p    = 32,
  parameter int unsigned idx_width_p = $clog2(rounds_p)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [127:0]           key_i,
  input  logic                   key_valid_i,
  output logic                   key_ready_o,
  output word_t                  rk_o,
  output logic [idx_width_p-1:0] rk_idx_o,
  output logic                   rk_valid_o,
  input  logic                   rk_ready_i,
  output logic                   done_o
);

  localparam logic [idx_width_p-1:0] LastIdx = idx_width_p'(rounds_p - 1);

  state_e                 state_q, state_d;
  word_t                  k_q [4];
  word_t                  k_d [4];
  logic [idx_width_p-1:0] cnt_q, cnt_d;
  logic                   done_q, done_d;

  word_t ck, mix, tau, rol13, rol23, rk;

`ifdef SM4_CK_ROM_EN
  assign ck = CkRom[5'(cnt_q)];
`else
  assign ck = ck_calc(5'(cnt_q));
`endif

  assign mix = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck;

  sm4_sbox32 u_sbox (
    .data_i (mix),
    .data_o (tau)
  );

  roll_shifter #(.Width(32), .Shift(13), .Left(1'b1)) u_rol13 (
    .data_i (tau),
    .data_o (rol13)
  );

  roll_shifter #(.Width(32), .Shift(23), .Left(1'b1)) u_rol23 (
    .data_i (tau),
    .data_o (rol23)
  );

  assign rk = k_q[0] ^ tau ^ rol13 ^ rol23;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key_valid_i) begin
          for (int j = 0; j < 4; j++) begin
            k_d[j] = key_i[127-32*j -: 32] ^ Fk[j];
          end
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (rk_ready_i) begin
          k_d[0] = k_q[1];
          k_d[1] = k_q[2];
          k_d[2] = k_q[3];
          k_d[3] = rk;
          if (cnt_q == LastIdx) begin
            cnt_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + idx_width_p'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      for (int j = 0; j < 4; j++) k_q[j] <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Outputs depend on registers only, so rk_o cannot glitch with rk_ready_i.
  assign key_ready_o = (state_q == StIdle);
  assign rk_valid_o  = (state_q == StRun);
  assign rk_o        = rk;
  assign rk_idx_o    = cnt_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_sm4_key_expander.sv
// Directed bench for sm4_key_expander: vector table plus reset and back-to-back sequences.
module tb_sm4_key_expander;
  import sm4_pkg::*;

  localparam int unsigned Rounds = 32;
  localparam int unsigned IdxW   = 5;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [127:0]    key_i;
  logic            key_valid_i;
  logic            key_ready_o;
  word_t           rk_o;
  logic [IdxW-1:0] rk_idx_o;
  logic            rk_valid_o;
  logic            rk_ready_i;
  logic            done_o;

  sm4_key_expander dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .key_i       (key_i),
    .key_valid_i (key_valid_i),
    .key_ready_o (key_ready_o),
    .rk_o        (rk_o),
    .rk_idx_o    (rk_idx_o),
    .rk_valid_o  (rk_valid_o),
    .rk_ready_i  (rk_ready_i),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  int    n_checks = 0;
  int    n_errors = 0;
  word_t exp_rk [Rounds];
  word_t got_rk [Rounds];
  int    n_got, n_done, n_valid, stab_err, idx_err, kr_err;
  logic  timed_out;

  typedef struct {
    logic [127:0] key;
    int           pct;
    word_t        rk0;
    word_t        rk1;
    word_t        rk31;
  } vec_t;

  vec_t vecs [5];

  localparam logic [127:0] KeyStd  = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KeyZero = 128'h0;
  localparam logic [127:0] KeyOnes = {128{1'b1}};
  localparam logic [127:0] KeyMisc = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] KeyAlt  = 128'hFEDCBA98765432100123456789ABCDEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference key schedule written straight from the algorithm definition.
  function automatic void run_model(input logic [127:0] key);
    word_t k [4];
    word_t fk [4];
    word_t ck, t, b, l;
    fk = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
    for (int j = 0; j < 4; j++) k[j] = key[127-32*j -: 32] ^ fk[j];
    for (int i = 0; i < Rounds; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((28 * i + 7 * j) % 256);
      t = k[1] ^ k[2] ^ k[3] ^ ck;
      b = {Sbox[t[31:24]], Sbox[t[23:16]], Sbox[t[15:8]], Sbox[t[7:0]]};
      l = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
      exp_rk[i] = k[0] ^ l;
      k[0] = k[1];
      k[1] = k[2];
      k[2] = k[3];
      k[3] = exp_rk[i];
    end
  endfunction

  // Consumes one stream starting at the current negedge; stops on the done_o cycle.
  task automatic collect(input int pct, input int budget);
    logic            stalled;
    logic            rdy;
    word_t           prev_rk;
    logic [IdxW-1:0] prev_idx;
    n_got = 0; n_done = 0; n_valid = 0; stab_err = 0; idx_err = 0; kr_err = 0;
    timed_out = 1'b1;
    stalled   = 1'b0;
    prev_rk   = '0;
    prev_idx  = '0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (rk_valid_o) begin
        n_valid++;
        if (stalled && (rk_o !== prev_rk || rk_idx_o !== prev_idx)) stab_err++;
        if (key_ready_o) kr_err++;
        rdy = (int'($urandom_range(99)) < pct);
        rk_ready_i = rdy;
        if (rdy) begin
          if (rk_idx_o !== IdxW'(n_got)) idx_err++;
          if (n_got < Rounds) got_rk[n_got] = rk_o;
          n_got++;
        end
        stalled  = !rdy;
        prev_rk  = rk_o;
        prev_idx = rk_idx_o;
      end else begin
        rk_ready_i = 1'b0;
        stalled    = 1'b0;
      end
      if (done_o) begin
        n_done++;
        timed_out = 1'b0;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic verify(input string tag, input bit full_rate);
    check({tag, "_timeout"}, 64'(timed_out), 64'(0));
    check({tag, "_nkeys"}, 64'(n_got), 64'(Rounds));
    check({tag, "_idx_seq_errs"}, 64'(idx_err), 64'(0));
    check({tag, "_stall_unstable"}, 64'(stab_err), 64'(0));
    check({tag, "_key_ready_in_run"}, 64'(kr_err), 64'(0));
    check({tag, "_done_count"}, 64'(n_done), 64'(1));
    if (full_rate) check({tag, "_valid_cycles"}, 64'(n_valid), 64'(Rounds));
    for (int i = 0; i < Rounds; i++) begin
      check($sformatf("%s_rk%0d", tag, i), 64'(got_rk[i]), 64'(exp_rk[i]));
    end
  endtask

  task automatic send_key(input string tag, input logic [127:0] k);
    @(negedge clk_i);
    key_i       = k;
    key_valid_i = 1'b1;
    @(negedge clk_i);
    key_valid_i = 1'b0;
    check({tag, "_first_valid"}, 64'(rk_valid_o), 64'(1));
    check({tag, "_first_idx"}, 64'(rk_idx_o), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_done;

    rst_ni      = 1'b0;
    key_i       = '0;
    key_valid_i = 1'b0;
    rk_ready_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset_key_ready", 64'(key_ready_o), 64'(1));
    check("reset_rk_valid", 64'(rk_valid_o), 64'(0));
    check("reset_done", 64'(done_o), 64'(0));
    check("reset_idx", 64'(rk_idx_o), 64'(0));
    rst_ni = 1'b1;

    vecs[0] = '{key: KeyStd, pct: 100, rk0: 32'hF12186F9, rk1: 32'h41662B61, rk31: 32'h9124A012};
    vecs[1] = '{key: KeyStd, pct: 30, rk0: 32'hF12186F9, rk1: 32'h41662B61, rk31: 32'h9124A012};
    run_model(KeyZero);
    vecs[2] = '{key: KeyZero, pct: 100, rk0: exp_rk[0], rk1: exp_rk[1], rk31: exp_rk[31]};
    run_model(KeyOnes);
    vecs[3] = '{key: KeyOnes, pct: 100, rk0: exp_rk[0], rk1: exp_rk[1], rk31: exp_rk[31]};
    run_model(KeyMisc);
    vecs[4] = '{key: KeyMisc, pct: 60, rk0: exp_rk[0], rk1: exp_rk[1], rk31: exp_rk[31]};

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      run_model(vecs[v].key);
      send_key(tag, vecs[v].key);
      collect(vecs[v].pct, 1000);
      verify(tag, vecs[v].pct == 100);
      check({tag, "_rk0"}, 64'(got_rk[0]), 64'(vecs[v].rk0));
      check({tag, "_rk1"}, 64'(got_rk[1]), 64'(vecs[v].rk1));
      check({tag, "_rk31"}, 64'(got_rk[31]), 64'(vecs[v].rk31));
      @(negedge clk_i);
      check({tag, "_done_single"}, 64'(done_o), 64'(0));
    end

    // Second key held valid throughout a running stream, then taken after one idle cycle.
    @(negedge clk_i);
    run_model(KeyStd);
    key_i       = KeyStd;
    key_valid_i = 1'b1;
    @(negedge clk_i);
    key_i = KeyAlt;
    check("b2b_first_valid", 64'(rk_valid_o), 64'(1));
    check("b2b_key_ready_run", 64'(key_ready_o), 64'(0));
    collect(100, 200);
    verify("b2b_a", 1'b1);
    check("b2b_gap_idle", 64'(rk_valid_o), 64'(0));
    check("b2b_gap_key_ready", 64'(key_ready_o), 64'(1));
    @(negedge clk_i);
    key_valid_i = 1'b0;
    check("b2b_second_valid", 64'(rk_valid_o), 64'(1));
    check("b2b_second_idx", 64'(rk_idx_o), 64'(0));
    run_model(KeyAlt);
    collect(100, 200);
    verify("b2b_b", 1'b1);

    // Reset in the middle of a stream.
    @(negedge clk_i);
    rk_ready_i = 1'b1;
    send_key("rst", KeyStd);
    rk_ready_i = 1'b1;
    for (int c = 0; c < 40 && rk_idx_o != IdxW'(10); c++) @(negedge clk_i);
    check("rst_reached_idx10", 64'(rk_idx_o), 64'(10));
    rst_ni = 1'b0;
    #1;
    check("rst_rk_valid", 64'(rk_valid_o), 64'(0));
    check("rst_key_ready", 64'(key_ready_o), 64'(1));
    check("rst_idx", 64'(rk_idx_o), 64'(0));
    saw_done = done_o;
    repeat (3) begin
      @(negedge clk_i);
      saw_done = saw_done | done_o;
    end
    check("rst_no_done", 64'(saw_done), 64'(0));
    rst_ni = 1'b1;
    run_model(KeyZero);
    send_key("rst_restart", KeyZero);
    collect(100, 200);
    verify("rst_restart", 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
